fifo_memory_param: RTL

- Parametrised synchronous single-clock FIFO. Successor to the fixed 8-bit FIFO buffer.
- Adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer in the same clock domain. The port names of the earlier FIFO are kept so existing benches drop in.

---
 rtl/fifo_memory_param.sv | 87 ++++++++
 1 files changed

// File: rtl/fifo_memory_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_memory_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write_enable,
    input  logic                    read_enable,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CW     = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  rd_acc, wr_acc;

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    assign rd_acc = read_enable && !empty;
    assign wr_acc = write_enable && (!full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
        else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
        if (write_enable && full && !rd_acc) ovf_d = 1'b1;
        if (read_enable && empty)            udf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            if (rd_acc) dout_q <= mem[rd_ptr_q];
        end
    end

    // Storage is left uncleared by reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_acc && !reset) mem[wr_ptr_q] <= data_in;
    end

    assign data_out     = dout_q;
    assign count        = count_q;
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
endmodule
